switch_mcu_wb_arbiter: RTL

//  Writeback stage directly upstream of the register file write port.

---
 rtl/switch_mcu_pkg.sv | 19 +
 rtl/switch_mcu_wb_fifo.sv | 56 +++++
 rtl/switch_mcu_wb_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/switch_mcu_pkg.sv
// Shared definitions for the switch MCU writeback path: load encodings,
// default widths and the round-robin source identifier.
package switch_mcu_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/switch_mcu_wb_fifo.sv
// Small synchronous FIFO with occupancy count; head is a combinational read
// of the oldest entry.
module switch_mcu_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_c,
  output logic [CW-1:0] count,
  output logic          full_c,
  output logic          empty_c
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;

  // Storage is not reset; validity is tracked by count alone.
  always_ff @(posedge in_clk) begin
    if (in_rst && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/switch_mcu_wb_arbiter.sv
// Writeback arbiter: queues ALU and load results, round-robins between them
// and drives the single register file write port.
module switch_mcu_wb_arbiter
  import switch_mcu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          in_alu_valid,
  output logic          out_alu_ready,
  input  logic [AW-1:0] in_alu_rd,
  input  logic [DW-1:0] in_alu_data,
  input  logic          in_lsu_valid,
  output logic          out_lsu_ready,
  input  logic [AW-1:0] in_lsu_rd,
  input  logic [DW-1:0] in_lsu_data,
  input  logic [2:0]    in_lsu_funct3,
  input  logic [1:0]    in_lsu_addr_lo,
  output logic [AW-1:0] out_waddr,
  output logic          out_wen,
  output logic [DW-1:0] out_wdata,
  output logic          out_idle
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned AWD = AW + DW;
  localparam int unsigned LWD = AW + DW + 5;

  logic [CW-1:0]  alu_count, lsu_count;
  logic           alu_full, lsu_full, alu_empty, lsu_empty;
  logic [AWD-1:0] alu_head;
  logic [LWD-1:0] lsu_head;
  logic           alu_push, lsu_push, alu_pop, lsu_pop;
  src_e           rr_q, rr_d;

  logic [AW-1:0]  lsu_rd;
  logic [DW-1:0]  lsu_word, lsu_ext;
  logic [2:0]     lsu_f3;
  logic [1:0]     lsu_lo;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;

  assign out_alu_ready = !alu_full;
  assign out_lsu_ready = !lsu_full;
  assign out_idle      = (alu_count == '0) && (lsu_count == '0) && !out_wen;

  // Writes to x0 are accepted but never occupy a slot.
  assign alu_push = in_alu_valid && out_alu_ready && (in_alu_rd != '0);
  assign lsu_push = in_lsu_valid && out_lsu_ready && (in_lsu_rd != '0);

  switch_mcu_wb_fifo #(.DEPTH(DEPTH), .W(AWD)) u_alu_fifo (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .push      (alu_push),
    .push_data ({in_alu_rd, in_alu_data}),
    .pop       (alu_pop),
    .head_c    (alu_head),
    .count     (alu_count),
    .full_c    (alu_full),
    .empty_c   (alu_empty)
  );

  switch_mcu_wb_fifo #(.DEPTH(DEPTH), .W(LWD)) u_lsu_fifo (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .push      (lsu_push),
    .push_data ({in_lsu_rd, in_lsu_data, in_lsu_funct3, in_lsu_addr_lo}),
    .pop       (lsu_pop),
    .head_c    (lsu_head),
    .count     (lsu_count),
    .full_c    (lsu_full),
    .empty_c   (lsu_empty)
  );

  // The pointer only moves when both heads compete.
  always_comb begin
    alu_pop = 1'b0;
    lsu_pop = 1'b0;
    rr_d    = rr_q;
    if (!alu_empty && !lsu_empty) begin
      if (rr_q == SRC_LSU) begin
        lsu_pop = 1'b1;
        rr_d    = SRC_ALU;
      end else begin
        alu_pop = 1'b1;
        rr_d    = SRC_LSU;
      end
    end else if (!alu_empty) begin
      alu_pop = 1'b1;
    end else if (!lsu_empty) begin
      lsu_pop = 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) rr_q <= SRC_LSU;
    else         rr_q <= rr_d;
  end

  assign lsu_rd   = lsu_head[LWD-1 -: AW];
  assign lsu_word = lsu_head[DW+4 -: DW];
  assign lsu_f3   = lsu_head[4:2];
  assign lsu_lo   = lsu_head[1:0];
  assign ld_byte  = lsu_word[{lsu_lo, 3'b000} +: 8];
  assign ld_half  = lsu_word[{lsu_lo[1], 4'b0000} +: 16];

  always_comb begin
    lsu_ext = lsu_word;
    case (lsu_f3)
      F3_LB:   lsu_ext = {{(DW-8){ld_byte[7]}}, ld_byte};
      F3_LH:   lsu_ext = {{(DW-16){ld_half[15]}}, ld_half};
      F3_LBU:  lsu_ext = {{(DW-8){1'b0}}, ld_byte};
      F3_LHU:  lsu_ext = {{(DW-16){1'b0}}, ld_half};
      F3_LW:   lsu_ext = lsu_word;
      default: lsu_ext = lsu_word;
    endcase
  end

  // Address/data hold their last value between writes.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      out_wen   <= 1'b0;
      out_waddr <= '0;
      out_wdata <= '0;
    end else begin
      out_wen <= alu_pop || lsu_pop;
      if (lsu_pop) begin
        out_waddr <= lsu_rd;
        out_wdata <= lsu_ext;
      end else if (alu_pop) begin
        {out_waddr, out_wdata} <= alu_head;
      end
    end
  end

endmodule
